// File: rtl/tile_fetch_ctrl.sv
// Per-scanline tile fetch sequencer: map RAM -> tile ROM -> line-buffer back bank,
// sharing the map RAM port with host writes. Optional UNDERRUN_CNT_EN adds underrun_cnt.
module tile_fetch_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        frame_start,
  input  logic        line_done,
  output logic [10:0] map_addr,
  output logic        map_rd_en,
  input  logic [7:0]  map_rdata,
  output logic        map_we,
  output logic [7:0]  map_wdata,
  output logic [15:0] rom_addr,
  output logic        rom_en,
  input  logic [15:0] rom_rdata,
  output logic [10:0] lb_waddr,
  output logic        lb_we,
  output logic [15:0] lb_wdata,
  output logic        lb_rd_bank,
  input  logic        host_req,
  input  logic [10:0] host_addr,
  input  logic [7:0]  host_data,
  output logic        host_ack,
`ifdef UNDERRUN_CNT_EN
  output logic        underrun,
  output logic [7:0]  underrun_cnt
`else
  output logic        underrun
`endif
);

  localparam int TILES = (H_ACTIVE / 16 < MAP_COLS) ? H_ACTIVE / 16 : MAP_COLS;
  localparam int LINES = (V_ACTIVE < MAP_ROWS * 16) ? V_ACTIVE : MAP_ROWS * 16;
  localparam logic [5:0] LAST_COL = 6'(TILES - 1);
  localparam logic [9:0] NUM_LINES = 10'(LINES);

  typedef enum logic [2:0] {IDLE, MAP_RD, MAP_WAIT, PIX, DONE} state_t;

  state_t      r_state, w_state_n;
  logic [9:0]  r_nxt_y, w_nxt_y_n;
  logic [5:0]  r_col, w_col_n;
  logic [3:0]  r_px, w_px_n;
  logic [7:0]  r_tile, w_tile_n;
  logic        r_bank, w_bank_n;
  logic        r_underrun, w_urun_evt;
  logic        r_gap, w_grant;
  logic        r_lb_we;
  logic [10:0] r_lb_waddr;
  logic [10:0] w_row_base;

  assign w_row_base = 11'(int'(r_nxt_y[9:4]) * MAP_COLS);

  // Host only gets the port in a quiet IDLE cycle; r_gap forces a bubble after each grant
  // and also blocks a grant during and just after reset.
  assign w_grant = (r_state == IDLE) && host_req && !r_gap && !frame_start && !line_done;

  always_comb begin
    w_state_n  = r_state;
    w_nxt_y_n  = r_nxt_y;
    w_col_n    = r_col;
    w_px_n     = r_px;
    w_tile_n   = r_tile;
    w_bank_n   = r_bank;
    w_urun_evt = 1'b0;
    map_addr   = '0;
    map_rd_en  = 1'b0;
    map_we     = 1'b0;
    map_wdata  = '0;
    rom_addr   = '0;
    rom_en     = 1'b0;
    host_ack   = 1'b0;

    case (r_state)
      MAP_RD: begin
        map_rd_en = 1'b1;
        map_addr  = w_row_base + 11'(r_col);
      end
      PIX: begin
        rom_en   = 1'b1;
        rom_addr = {r_tile, r_nxt_y[3:0], r_px};
      end
      IDLE: begin
        if (w_grant) begin
          map_we    = 1'b1;
          map_addr  = host_addr;
          map_wdata = host_data;
          host_ack  = 1'b1;
        end
      end
      default: ;
    endcase

    // Line/frame pulses override whatever the sequencer was doing.
    if (frame_start) begin
      w_nxt_y_n = '0;
      w_col_n   = '0;
      w_state_n = MAP_RD;
      if (line_done) w_bank_n = ~r_bank;
    end else if (line_done) begin
      w_bank_n = ~r_bank;
      if (r_state == IDLE) begin
        if (r_nxt_y < NUM_LINES) w_state_n = MAP_RD;
      end else begin
        w_urun_evt = 1'b1;
        w_nxt_y_n  = r_nxt_y + 10'd1;
        w_col_n    = '0;
        w_state_n  = MAP_RD;
      end
    end else begin
      case (r_state)
        MAP_RD:   w_state_n = MAP_WAIT;
        MAP_WAIT: begin
          w_tile_n  = map_rdata;
          w_px_n    = '0;
          w_state_n = PIX;
        end
        PIX: begin
          w_px_n = r_px + 4'd1;
          if (r_px == 4'd15) begin
            if (r_col == LAST_COL) begin
              w_state_n = DONE;
            end else begin
              w_col_n   = r_col + 6'd1;
              w_state_n = MAP_RD;
            end
          end
        end
        DONE: begin
          w_nxt_y_n = r_nxt_y + 10'd1;
          w_col_n   = '0;
          w_state_n = IDLE;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_nxt_y    <= '0;
      r_col      <= '0;
      r_px       <= '0;
      r_tile     <= '0;
      r_bank     <= 1'b0;
      r_underrun <= 1'b0;
      r_gap      <= 1'b1;
      r_lb_we    <= 1'b0;
      r_lb_waddr <= '0;
    end else begin
      r_state    <= w_state_n;
      r_nxt_y    <= w_nxt_y_n;
      r_col      <= w_col_n;
      r_px       <= w_px_n;
      r_tile     <= w_tile_n;
      r_bank     <= w_bank_n;
      r_underrun <= r_underrun | w_urun_evt;
      r_gap      <= w_grant;
      // Write side trails the ROM read by one cycle; bank sampled before any toggle.
      r_lb_we    <= rom_en;
      r_lb_waddr <= {~r_bank, r_col, r_px};
    end
  end

  assign lb_we      = r_lb_we;
  assign lb_waddr   = r_lb_waddr;
  assign lb_wdata   = r_lb_we ? rom_rdata : '0;
  assign lb_rd_bank = r_bank;
  assign underrun   = r_underrun;

`ifdef UNDERRUN_CNT_EN
  logic [7:0] r_urun_cnt;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                            r_urun_cnt <= '0;
    else if (w_urun_evt && r_urun_cnt != 8'hFF) r_urun_cnt <= r_urun_cnt + 8'd1;
  end

  assign underrun_cnt = r_urun_cnt;
`endif

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Directed bench for tile_fetch_ctrl with behavioural map RAM and tile ROM models.
module tb_tile_fetch_ctrl;
  logic        vga_clk = 1'b0;
  logic        sys_rst_n, frame_start, line_done;
  logic [10:0] map_addr;
  logic        map_rd_en, map_we;
  logic [7:0]  map_rdata, map_wdata;
  logic [15:0] rom_addr, rom_rdata;
  logic        rom_en;
  logic [10:0] lb_waddr;
  logic        lb_we, lb_rd_bank;
  logic [15:0] lb_wdata;
  logic        host_req, host_ack, underrun;
  logic [10:0] host_addr;
  logic [7:0]  host_data;
`ifdef UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  always #5 vga_clk = ~vga_clk;

  tile_fetch_ctrl dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start), .line_done(line_done),
    .map_addr(map_addr), .map_rd_en(map_rd_en), .map_rdata(map_rdata), .map_we(map_we),
    .map_wdata(map_wdata), .rom_addr(rom_addr), .rom_en(rom_en), .rom_rdata(rom_rdata),
    .lb_waddr(lb_waddr), .lb_we(lb_we), .lb_wdata(lb_wdata), .lb_rd_bank(lb_rd_bank),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
`ifdef UNDERRUN_CNT_EN
    .underrun(underrun), .underrun_cnt(underrun_cnt)
`else
    .underrun(underrun)
`endif
  );

  // Synchronous map RAM and tile ROM: data one cycle after the strobe.
  logic [7:0] mem [0:2047] = '{default: 8'h00};
  always @(posedge vga_clk) begin
    if (map_rd_en) map_rdata <= mem[map_addr];
    if (map_we)    mem[map_addr] <= map_wdata;
    if (rom_en)    rom_rdata <= {rom_addr[7:0], rom_addr[7:0]};
  end

  int n_chk = 0, n_fail = 0;
  int err_map, err_rom, err_lb, err_host, nrd, nrom, nwe, last_we, ack_k, rd_c2, rom_c2, tot, act;
  logic [10:0] ack_addr;
  logic [7:0]  ack_data;
  logic        exp_bank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{map_addr, map_rd_en, map_we, map_wdata, rom_addr, rom_en, lb_waddr, lb_we,
             lb_wdata, lb_rd_bank, host_ack, underrun};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge vga_clk); #1; end
  endtask

  task automatic pulse(input logic fs, input logic ld);
    frame_start = fs;
    line_done   = ld;
    if (ld) exp_bank = ~exp_bank;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    line_done   = 1'b0;
  endtask

  // Watches ncyc cycles after a pulse and scores every strobe against the expected line y.
  task automatic observe(input int y, input int ncyc, input int host_at);
    int base;
    logic [7:0]  t;
    logic [15:0] ea;
    base = (y / 16) * 40;
    err_map = 0; err_rom = 0; err_lb = 0; err_host = 0;
    nrd = 0; nrom = 0; nwe = 0; last_we = -1; ack_k = -1; rd_c2 = -1; rom_c2 = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge vga_clk);
      if (map_rd_en) begin
        if (map_addr !== 11'(base + nrd)) err_map++;
        if (nrd == 2) rd_c2 = int'(map_addr);
        nrd++;
      end
      if (rom_en) begin
        t  = mem[base + nrom / 16];
        ea = {t, 4'(y % 16), 4'(nrom % 16)};
        if (rom_addr !== ea) err_rom++;
        if (nrom == 32) rom_c2 = int'(rom_addr);
        nrom++;
      end
      if (lb_we) begin
        if (lb_waddr !== {~exp_bank, 10'(nwe)} ||
            lb_wdata !== {4'(y % 16), 4'(nwe % 16), 4'(y % 16), 4'(nwe % 16)}) err_lb++;
        last_we = k;
        nwe++;
      end
      if (map_we !== host_ack || (host_ack && !host_req)) err_host++;
      if (host_ack && ack_k < 0) begin
        ack_k = k; ack_addr = map_addr; ack_data = map_wdata;
      end
      if (k == host_at) host_req = 1'b1;
      @(posedge vga_clk); #1;
      if (ack_k == k) host_req = 1'b0;
    end
  endtask

  task automatic host_wr(input string tag, input logic [10:0] a, input logic [7:0] d);
    logic got;
    int   lat;
    host_addr = a; host_data = d; host_req = 1'b1;
    got = 1'b0; lat = -1;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge vga_clk);
      if (host_ack) begin
        got = 1'b1; lat = c;
        chk({tag, "_we_addr"}, {map_we, map_addr, map_wdata}, {1'b1, a, d});
      end
      @(posedge vga_clk); #1;
    end
    host_req = 1'b0;
    chk({tag, "_ack_in_2"}, (got && lat < 2), 1);
    chk({tag, "_mem"}, mem[a], d);
  endtask

  initial begin
    sys_rst_n = 1'b0; frame_start = 1'b0; line_done = 1'b0;
    host_req = 1'b1; host_addr = 11'd7; host_data = 8'hEE; exp_bank = 1'b0;
    cyc(3);
    @(negedge vga_clk);
    chk("rst_outs_zero", any_out(), 0);
    host_req = 1'b0;
    @(posedge vga_clk); #1;
    sys_rst_n = 1'b1;
    cyc(2);

    // Map entry (row 1, col 2) = 0x05 via the host path while idle.
    host_wr("init_wr", 11'd42, 8'h05);
    cyc(2);

    // Line 0 from frame_start.
    pulse(1'b1, 1'b0);
    observe(0, 730, 0);
    chk("l0_map_rd_cnt", nrd, 40);
    chk("l0_map_addr_err", err_map, 0);
    chk("l0_rom_cnt", nrom, 640);
    chk("l0_rom_addr_err", err_rom, 0);
    chk("l0_lb_we_cnt", nwe, 640);
    chk("l0_lb_err", err_lb, 0);
    chk("l0_done_cycle", last_we, 721);
    chk("l0_idle", {map_rd_en, rom_en, lb_we, lb_rd_bank, underrun}, 0);

    tot = 0;
    for (int y = 1; y <= 16; y++) begin
      pulse(1'b0, 1'b1);
      observe(y, 730, 0);
      tot += err_map + err_rom + err_lb + err_host + (nwe != 640 ? 1 : 0) + (last_we != 721 ? 1 : 0);
    end
    chk("l1_16_err", tot, 0);

    // Line 17: row 1, col 2 carries tile 5.
    pulse(1'b0, 1'b1);
    observe(17, 730, 0);
    chk("l17_map_addr_c2", rd_c2, 42);
    chk("l17_rom_addr_c2", rom_c2, 32'h0510);
    chk("l17_err", err_map + err_rom + err_lb, 0);
    chk("l17_lb_we_cnt", nwe, 640);

    // Host request raised mid-PIX is held off until IDLE after DONE.
    host_addr = 11'd100; host_data = 8'hAB;
    pulse(1'b0, 1'b1);
    observe(18, 730, 100);
    chk("host_ack_cycle", ack_k, 722);
    chk("host_ack_addr", ack_addr, 100);
    chk("host_ack_data", ack_data, 8'hAB);
    chk("host_path_err", err_host, 0);
    chk("host_mem100", mem[100], 8'hAB);
    chk("l18_err", err_map + err_rom + err_lb, 0);

    // line_done 300 cycles into a fetch: abort with underrun.
    pulse(1'b1, 1'b0);
    observe(0, 299, 0);
    chk("urun_before", underrun, 0);
    pulse(1'b0, 1'b1);
    @(negedge vga_clk);
    chk("urun_inflight_we", lb_we, 1);
    chk("urun_inflight_addr", lb_waddr, 11'd1289);
    chk("urun_restart", {map_rd_en, map_addr}, {1'b1, 11'd0});
    chk("urun_flag", underrun, 1);
    chk("urun_bank", lb_rd_bank, exp_bank);
`ifdef UNDERRUN_CNT_EN
    chk("urun_cnt1", underrun_cnt, 1);
`endif
    @(posedge vga_clk); #1;
    @(negedge vga_clk);
    chk("urun_rom_dropped", {lb_we, rom_en}, 0);
    cyc(726);

    // Race nxt_y to 479 by aborting, then let line 479 finish.
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 479; i++) begin
      pulse(1'b0, 1'b1);
      if (i < 478) cyc(1);
    end
    observe(479, 730, 0);
    chk("l479_err", err_map + err_rom + err_lb + err_host, 0);
    chk("l479_done_cycle", last_we, 721);
`ifdef UNDERRUN_CNT_EN
    chk("urun_cnt_sat", underrun_cnt, 255);
`endif
    pulse(1'b0, 1'b1);
    observe(480, 40, 0);
    chk("vblank_no_fetch", nrd + nrom + nwe, 0);
    chk("vblank_bank", lb_rd_bank, exp_bank);
    for (int w = 0; w < 3; w++) host_wr("vblank_wr", 11'(200 + w), 8'(8'h30 + w));

    // Asynchronous reset mid-PIX.
    pulse(1'b1, 1'b0);
    observe(0, 49, 0);
    @(negedge vga_clk);
    host_req  = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_outs", any_out(), 0);
    host_req = 1'b0;
    @(posedge vga_clk); #1;
    cyc(2);
    sys_rst_n = 1'b1;
    exp_bank  = 1'b0;
    act = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge vga_clk);
      act += int'(map_rd_en | rom_en | lb_we | map_we | underrun);
      @(posedge vga_clk); #1;
    end
    chk("post_rst_quiet", act, 0);
    pulse(1'b1, 1'b0);
    observe(0, 730, 0);
    chk("post_rst_l0_err", err_map + err_rom + err_lb + err_host, 0);
    chk("post_rst_l0_we", nwe, 640);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_fetch_ctrl.md
Name: tile_fetch_ctrl

Overview:
- Per-scanline tile fetch sequencer feeding the tile-based VGA draw path (640x480, RGB565, 16x16 tiles, 40x30 tile map).
- While line N is displayed from one line-buffer bank, it reads line N+1's tile indices from the map RAM and the tile pixel rows from the tile ROM into the other bank.
- It also arbitrates the single map-RAM port between the fetcher and host (game-logic) entity-code writes, using a req/ack handshake.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MAP_COLS, 40, tiles per map row
- MAP_ROWS, 30, tile rows per map

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at vsync start; prepare line 0
- line_done  in  1  one-cycle pulse at end of each active line; swap banks, prepare next line
- map_addr  out  11  map RAM address, row*40+col (0..1199)
- map_rd_en  out  1  map RAM read strobe; data valid 1 cycle later
- map_rdata  in  8  tile index
- map_we  out  1  map RAM write strobe (host path)
- map_wdata  out  8  map RAM write data
- rom_addr  out  16  tile ROM address {tile[7:0], row[3:0], col[3:0]}
- rom_en  out  1  ROM read strobe; data valid 1 cycle later
- rom_rdata  in  16  RGB565 pixel
- lb_waddr  out  11  line-buffer write address {bank, x[9:0]}
- lb_we  out  1  line-buffer write strobe
- lb_wdata  out  16  line-buffer write data
- lb_rd_bank  out  1  bank currently displayed
- host_req  in  1  host write request; held until ack
- host_addr  in  11  host map address
- host_data  in  8  host map data
- host_ack  out  1  one-cycle pulse; write performed this cycle
- underrun  out  1  sticky: line_done arrived while a fetch was in progress

Behaviour:
- Reset values: every output 0; FSM in IDLE; line counter nxt_y = 0; lb_rd_bank = 0; underrun = 0.
- FSM states: IDLE, MAP_RD, MAP_WAIT, PIX, DONE.
- IDLE:
  - frame_start: nxt_y <= 0, go to MAP_RD.
  - line_done: lb_rd_bank toggles. If nxt_y < V_ACTIVE, go to MAP_RD. Otherwise (vblank) stay in IDLE.
- MAP_RD:
  - map_rd_en = 1, map_addr = (nxt_y>>4)*40 + col. col is the tile counter, 0..39.
  - Go to MAP_WAIT.
- MAP_WAIT: latch map_rdata as the tile index; px = 0; go to PIX.
- PIX:
  - Per cycle: rom_en = 1, rom_addr = {tile, nxt_y[3:0], px}, px increments.
  - After px = 15: if col = 39, go to DONE; otherwise col++ and go to MAP_RD.
- Write pipeline:
  - lb_we, lb_wdata and lb_waddr are rom_en / rom_rdata / {~lb_rd_bank, col*16+px} registered by one cycle.
  - The last pixel is therefore written in the DONE cycle.
- DONE: nxt_y++, col = 0, go to IDLE.
- Per-line cost: 40*18 + 1 = 721 cycles, within the 800-cycle line period.
- Arbitration:
  - The host is granted only in IDLE with no frame_start/line_done pulse that same cycle.
  - On grant: map_we = 1, map_addr = host_addr, map_wdata = host_data, host_ack = 1. Granting returns to IDLE; at most one grant per 2 cycles.
  - The fetcher always wins a same-cycle conflict.
- line_done outside IDLE:
  - Set underrun and abort the current fetch: remaining ROM reads are dropped, but the pipelined write in flight completes.
  - Toggle lb_rd_bank, increment nxt_y, restart at MAP_RD with col = 0.
- frame_start outside IDLE: abort, nxt_y = 0, restart. This does not set underrun.
- Simultaneous frame_start and line_done: frame_start takes priority, and lb_rd_bank is also toggled.
- underrun clears only on reset.
- sys_rst_n low mid-fetch: all outputs clear immediately (async); fetch and any host request are abandoned.
- Host with host_req low: map_we stays 0.

Optional Feature:
- Macro UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [7:0]. It increments on every underrun event, saturates at 255 and resets to 0.
- Undefined: the port and counter are absent; underrun flag behaviour is unchanged.

Test Plan:
- Reset, then frame_start; map all zeros; ROM returns {addr[7:0],addr[7:0]} -> map_addr 0..39 in order, 640 lb_we pulses on bank 1, x = 0..639, DONE 721 cycles after frame_start; nxt_y = 1.
- Map entry (row 1, col 2) = 0x05; prepare line 17 -> map_addr 42 read; rom_addr 0x0510..0x051F; writes at x = 32..47.
- host_req held with addr 100, data 0xAB, asserted during PIX -> host_ack only after DONE, in IDLE; map_we with addr 100, data 0xAB in the same cycle as ack.
- line_done 300 cycles after frame_start -> underrun = 1, lb_rd_bank toggles, fetch restarts at map_addr for nxt_y = 1 (address 0); with UNDERRUN_CNT_EN, underrun_cnt = 1.
- After line 479's DONE, line_done pulses -> no fetch (nxt_y = 480); host writes acknowledged within 2 cycles each.
- sys_rst_n pulsed low mid-PIX -> all outputs 0 asynchronously; after release, no activity until frame_start.
